// File: rtl/amdc_axil_pkg.sv
// Shared definitions for the AMDC AXI4-Lite register slave: bus widths,
// response codes, channel FSM state encodings and a byte-lane merge helper.
package amdc_axil_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set, keeping the rest.
  function automatic logic [DATA_WIDTH-1:0] applyStrobe(
    input logic [DATA_WIDTH-1:0] oldWord,
    input logic [DATA_WIDTH-1:0] newWord,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] result;
    result = oldWord;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) begin
        result[8*b +: 8] = newWord[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/amdc_axil_wr_join.sv
// Write-side join for the AXI4-Lite register slave. AW and W may arrive in
// any order; each is parked in a hold register until its partner shows up.
// The edge on which both are available is the commit edge: the parent
// updates its register file from commit*_o, and this block raises BVALID.
module amdc_axil_wr_join
  import amdc_axil_pkg::*;
#(
  parameter int IDX_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_WIDTH-1:0]  awIdx_i,
  input  logic                  awValid_i,
  output logic                  awReady_o,
  input  logic [DATA_WIDTH-1:0] wData_i,
  input  logic [STRB_WIDTH-1:0] wStrb_i,
  input  logic                  wValid_i,
  output logic                  wReady_o,
  output logic                  bValid_o,
  input  logic                  bReady_i,
  output logic                  commit_o,
  output logic [IDX_WIDTH-1:0]  commitIdx_o,
  output logic [DATA_WIDTH-1:0] commitData_o,
  output logic [STRB_WIDTH-1:0] commitStrb_o
);

  wr_state_t             state_q;
  logic                  awHeld_q;
  logic                  wHeld_q;
  logic                  awReady_q;
  logic                  wReady_q;
  logic                  bValid_q;
  logic [IDX_WIDTH-1:0]  awIdx_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [STRB_WIDTH-1:0] wStrb_q;

  logic awHs;
  logic wHs;

  // Join condition: each half is available if parked or handshaking right now.
  always_comb begin
    awHs         = awValid_i && awReady_q;
    wHs          = wValid_i && wReady_q;
    commit_o     = (state_q == WR_IDLE) && (awHeld_q || awHs) && (wHeld_q || wHs);
    commitIdx_o  = awHeld_q ? awIdx_q : awIdx_i;
    commitData_o = wHeld_q ? wData_q : wData_i;
    commitStrb_o = wHeld_q ? wStrb_q : wStrb_i;
  end

  // Write FSM: park AW/W halves, commit when joined, then hold B until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WR_IDLE;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awReady_q <= 1'b1;
      wReady_q  <= 1'b1;
      bValid_q  <= 1'b0;
      awIdx_q   <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
    end else begin
      unique case (state_q)
        WR_IDLE: begin
          if (commit_o) begin
            state_q   <= WR_RESP;
            bValid_q  <= 1'b1;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
          end else begin
            if (awHs) begin
              awHeld_q  <= 1'b1;
              awIdx_q   <= awIdx_i;
              awReady_q <= 1'b0;
            end
            if (wHs) begin
              wHeld_q  <= 1'b1;
              wData_q  <= wData_i;
              wStrb_q  <= wStrb_i;
              wReady_q <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (bReady_i) begin
            state_q   <= WR_IDLE;
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
          end
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign awReady_o = awReady_q;
  assign wReady_o  = wReady_q;
  assign bValid_o  = bValid_q;

endmodule

// File: rtl/amdc_axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write control registers.
// Write and read channels run independently; all outputs are registered.
// Optional build macro AMDC_AXIL_SLVERR_EN: out-of-range accesses answer
// SLVERR instead of OKAY (writes are dropped and reads return 0 either way).
module amdc_axil_reg_slave
  import amdc_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0]          S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

`ifdef AMDC_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = AXI_RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = AXI_RESP_OKAY;
`endif

  // Word indices at or above NUM_REGS have no backing register.
  function automatic logic idxInRange(input logic [IDX_WIDTH-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wrPulse_q;
  logic [1:0]            bResp_q;

  rd_state_t             rdState_q;
  logic                  arReady_q;
  logic                  rValid_q;
  logic [DATA_WIDTH-1:0] rData_q;
  logic [1:0]            rResp_q;

  logic                  commit;
  logic [IDX_WIDTH-1:0]  commitIdx;
  logic [DATA_WIDTH-1:0] commitData;
  logic [STRB_WIDTH-1:0] commitStrb;
  logic                  wrInRange;
  logic [NUM_REGS-1:0]   wrHit;

  logic [IDX_WIDTH-1:0]  rdIdx;
  logic                  rdInRange;
  logic [DATA_WIDTH-1:0] rdMux;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unusedInputs;
  assign unusedInputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  amdc_axil_wr_join #(
    .IDX_WIDTH(IDX_WIDTH)
  ) uWrJoin (
    .clk_i        (ACLK),
    .rst_i        (ARESET),
    .awIdx_i      (S_AXI_AWADDR[ADDR_WIDTH-1:2]),
    .awValid_i    (S_AXI_AWVALID),
    .awReady_o    (S_AXI_AWREADY),
    .wData_i      (S_AXI_WDATA),
    .wStrb_i      (S_AXI_WSTRB),
    .wValid_i     (S_AXI_WVALID),
    .wReady_o     (S_AXI_WREADY),
    .bValid_o     (S_AXI_BVALID),
    .bReady_i     (S_AXI_BREADY),
    .commit_o     (commit),
    .commitIdx_o  (commitIdx),
    .commitData_o (commitData),
    .commitStrb_o (commitStrb)
  );

  // Decode which register, if any, the committing write targets.
  always_comb begin
    wrInRange = idxInRange(commitIdx);
    wrHit     = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wrHit[k] = commit && wrInRange && (commitIdx == IDX_WIDTH'(k));
    end
  end

  // Register file update with byte strobes, plus the one-cycle write pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      wrPulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wrHit[k]) begin
          regs_q[k] <= applyStrobe(regs_q[k], commitData, commitStrb);
        end
        wrPulse_q[k] <= wrHit[k] && (|commitStrb);
      end
    end
  end

  // Write response code is captured on the commit edge and held through B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bResp_q <= AXI_RESP_OKAY;
    end else if (commit) begin
      bResp_q <= wrInRange ? AXI_RESP_OKAY : OOR_RESP;
    end
  end

  // Read address decode; an unmatched index naturally selects zero.
  always_comb begin
    rdIdx     = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    rdInRange = idxInRange(rdIdx);
    rdMux     = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rdIdx == IDX_WIDTH'(k)) begin
        rdMux = regs_q[k];
      end
    end
  end

  // Read FSM: capture data on the AR handshake, hold R until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdState_q <= RD_IDLE;
      arReady_q <= 1'b1;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= AXI_RESP_OKAY;
    end else begin
      unique case (rdState_q)
        RD_IDLE: begin
          if (S_AXI_ARVALID && arReady_q) begin
            rData_q   <= rdInRange ? rdMux : '0;
            rResp_q   <= rdInRange ? AXI_RESP_OKAY : OOR_RESP;
            rValid_q  <= 1'b1;
            arReady_q <= 1'b0;
            rdState_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rValid_q  <= 1'b0;
            arReady_q <= 1'b1;
            rdState_q <= RD_IDLE;
          end
        end
        default: rdState_q <= RD_IDLE;
      endcase
    end
  end

  // Flatten the register file onto the downstream bus.
  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
    end
  end

  assign S_AXI_BRESP   = bResp_q;
  assign S_AXI_ARREADY = arReady_q;
  assign S_AXI_RVALID  = rValid_q;
  assign S_AXI_RDATA   = rData_q;
  assign S_AXI_RRESP   = rResp_q;
  assign reg_wr_pulse  = wrPulse_q;

endmodule

// File: tb/tb_amdc_axil_reg_slave.sv
// Self-checking bench for amdc_axil_reg_slave (ADDR_WIDTH=5, NUM_REGS=4).
// A transaction-level model (queues of accepted AW/W halves, a plain register
// array) predicts every output each cycle; directed sequences pin literal values.
module tb_amdc_axil_reg_slave;

  localparam int AW = 5;
  localparam int NR = 4;

`ifdef AMDC_AXIL_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic           ACLK = 1'b0;
  logic           ARESET;
  logic [AW-1:0]  S_AXI_AWADDR;
  logic [2:0]     S_AXI_AWPROT;
  logic           S_AXI_AWVALID;
  logic           S_AXI_AWREADY;
  logic [31:0]    S_AXI_WDATA;
  logic [3:0]     S_AXI_WSTRB;
  logic           S_AXI_WVALID;
  logic           S_AXI_WREADY;
  logic [1:0]     S_AXI_BRESP;
  logic           S_AXI_BVALID;
  logic           S_AXI_BREADY;
  logic [AW-1:0]  S_AXI_ARADDR;
  logic [2:0]     S_AXI_ARPROT;
  logic           S_AXI_ARVALID;
  logic           S_AXI_ARREADY;
  logic [31:0]    S_AXI_RDATA;
  logic [1:0]     S_AXI_RRESP;
  logic           S_AXI_RVALID;
  logic           S_AXI_RREADY;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0]  reg_wr_pulse;

  int vectors = 0;
  int miscompares = 0;

  amdc_axil_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // Free-running bus clock, period 10.
  always #5 ACLK = ~ACLK;

  // Transaction-level reference state.
  logic [31:0] mRegs [NR] = '{default: '0};
  int          awQ [$];
  logic [35:0] wQ [$];
  logic        eAwReady = 1'b1, eWReady = 1'b1, eArReady = 1'b1;
  logic        eBValid = 1'b0, eRValid = 1'b0;
  logic [1:0]  eBResp = 2'b00, eRResp = 2'b00;
  logic [31:0] eRData = '0;
  logic [3:0]  ePulse = '0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    int a;
    logic [35:0] wd;
    if (ARESET) begin
      for (int k = 0; k < NR; k++) mRegs[k] = '0;
      awQ.delete(); wQ.delete();
      eAwReady = 1; eWReady = 1; eArReady = 1;
      eBValid = 0; eRValid = 0; eBResp = 0; eRResp = 0; eRData = 0; ePulse = 0;
      return;
    end
    ePulse = 0;
    // Reads observe register contents from before any write landing this edge.
    if (eRValid) begin
      if (S_AXI_RREADY) begin eRValid = 0; eArReady = 1; end
    end else if (S_AXI_ARVALID && eArReady) begin
      a = int'(S_AXI_ARADDR) / 4;
      eRData = (a < NR) ? mRegs[a] : 32'h0;
      eRResp = (a < NR) ? 2'b00 : OOR;
      eRValid = 1; eArReady = 0;
    end
    if (eBValid) begin
      if (S_AXI_BREADY) eBValid = 0;
    end else begin
      if (S_AXI_AWVALID && eAwReady) awQ.push_back(int'(S_AXI_AWADDR) / 4);
      if (S_AXI_WVALID && eWReady) wQ.push_back({S_AXI_WSTRB, S_AXI_WDATA});
      if (awQ.size() > 0 && wQ.size() > 0) begin
        a = awQ.pop_front();
        wd = wQ.pop_front();
        eBValid = 1;
        if (a < NR) begin
          for (int b = 0; b < 4; b++)
            if (wd[32+b]) mRegs[a][8*b +: 8] = wd[8*b +: 8];
          ePulse[a] = |wd[35:32];
          eBResp = 2'b00;
        end else begin
          eBResp = OOR;
        end
      end
    end
    eAwReady = !eBValid && (awQ.size() == 0);
    eWReady  = !eBValid && (wQ.size() == 0);
  endtask

  // Compare every DUT output against the reference just after each edge.
  always @(posedge ACLK) begin
    modelStep();
    #1;
    checkOutput("awready", S_AXI_AWREADY, eAwReady);
    checkOutput("wready",  S_AXI_WREADY,  eWReady);
    checkOutput("bvalid",  S_AXI_BVALID,  eBValid);
    checkOutput("bresp",   S_AXI_BRESP,   eBResp);
    checkOutput("arready", S_AXI_ARREADY, eArReady);
    checkOutput("rvalid",  S_AXI_RVALID,  eRValid);
    checkOutput("rdata",   S_AXI_RDATA,   eRData);
    checkOutput("rresp",   S_AXI_RRESP,   eRResp);
    checkOutput("reg_out", reg_out, {mRegs[3], mRegs[2], mRegs[1], mRegs[0]});
    checkOutput("wr_pulse", reg_wr_pulse, ePulse);
  end

  task automatic writeReg(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wLead, input int hold,
                          input logic [1:0] expResp, output logic [3:0] pulse);
    logic awDone, wDone, awFire, wFire;
    int cyc;
    awDone = 0; wDone = 0; cyc = 0;
    S_AXI_BREADY = (hold == 0);
    while (!(awDone && wDone) && cyc < 40) begin
      @(negedge ACLK);
      if (wDone && !awDone) checkOutput("wready_after_w", S_AXI_WREADY, 1'b0);
      S_AXI_AWADDR = addr;
      S_AXI_AWVALID = !awDone && (cyc >= wLead);
      S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_WVALID = !wDone;
      awFire = S_AXI_AWVALID && S_AXI_AWREADY;
      wFire = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      awDone |= awFire; wDone |= wFire; cyc++;
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    checkOutput("bvalid_latency", S_AXI_BVALID, 1'b1);
    checkOutput("bresp_value", S_AXI_BRESP, expResp);
    pulse = reg_wr_pulse;
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_bvalid", S_AXI_BVALID, 1'b1);
      checkOutput("hold_bresp", S_AXI_BRESP, expResp);
      checkOutput("hold_awready", S_AXI_AWREADY, 1'b0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1;
    @(negedge ACLK);
  endtask

  task automatic readReg(input logic [AW-1:0] addr, input int hold,
                         input logic [31:0] expData, input logic [1:0] expResp);
    logic done, fire;
    int cyc;
    done = 0; cyc = 0;
    S_AXI_RREADY = (hold == 0);
    while (!done && cyc < 40) begin
      @(negedge ACLK);
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
      fire = S_AXI_ARREADY;
      @(posedge ACLK);
      done = fire; cyc++;
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    checkOutput("rvalid_latency", S_AXI_RVALID, 1'b1);
    checkOutput("rdata_value", S_AXI_RDATA, expData);
    checkOutput("rresp_value", S_AXI_RRESP, expResp);
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_rvalid", S_AXI_RVALID, 1'b1);
      checkOutput("hold_rdata", S_AXI_RDATA, expData);
      checkOutput("hold_arready", S_AXI_ARREADY, 1'b0);
      @(negedge ACLK);
    end
    S_AXI_RREADY = 1;
    @(negedge ACLK);
  endtask

  // Random AXI-legal traffic: payloads stay put until accepted, rare resets.
  task automatic applyStimulus(input int cycles);
    logic awFire, wFire, arFire;
    awFire = 0; wFire = 0; arFire = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge ACLK);
      if ($urandom_range(0, 299) == 0) begin
        ARESET = 1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        awFire = 0; wFire = 0; arFire = 0;
        continue;
      end
      ARESET = 0;
      if (awFire || !S_AXI_AWVALID) begin
        S_AXI_AWVALID = $urandom_range(0, 1) == 1;
        S_AXI_AWADDR = AW'($urandom_range(0, 31));
      end
      if (wFire || !S_AXI_WVALID) begin
        S_AXI_WVALID = $urandom_range(0, 1) == 1;
        S_AXI_WDATA = $urandom;
        S_AXI_WSTRB = 4'($urandom_range(0, 15));
      end
      if (arFire || !S_AXI_ARVALID) begin
        S_AXI_ARVALID = $urandom_range(0, 1) == 1;
        S_AXI_ARADDR = AW'($urandom_range(0, 31));
      end
      S_AXI_BREADY = $urandom_range(0, 3) != 0;
      S_AXI_RREADY = $urandom_range(0, 3) != 0;
      awFire = S_AXI_AWVALID && S_AXI_AWREADY;
      wFire  = S_AXI_WVALID && S_AXI_WREADY;
      arFire = S_AXI_ARVALID && S_AXI_ARREADY;
    end
    @(negedge ACLK);
    ARESET = 0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    repeat (6) @(negedge ACLK);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] pulse;

  initial begin
    ARESET = 1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    repeat (2) @(negedge ACLK);
    checkOutput("reset_awready", S_AXI_AWREADY, 1'b1);
    checkOutput("reset_wready", S_AXI_WREADY, 1'b1);
    checkOutput("reset_arready", S_AXI_ARREADY, 1'b1);
    checkOutput("reset_bvalid", S_AXI_BVALID, 1'b0);
    checkOutput("reset_regout", reg_out, 128'h0);
    ARESET = 0;

    writeReg(5'h00, 32'd1, 4'hF, 0, 0, 2'b00, pulse); checkOutput("pulse_r0", pulse, 4'b0001);
    writeReg(5'h04, 32'd2, 4'hF, 0, 0, 2'b00, pulse); checkOutput("pulse_r1", pulse, 4'b0010);
    writeReg(5'h08, 32'd3, 4'hF, 0, 0, 2'b00, pulse); checkOutput("pulse_r2", pulse, 4'b0100);
    writeReg(5'h0C, 32'd4, 4'hF, 0, 0, 2'b00, pulse); checkOutput("pulse_r3", pulse, 4'b1000);
    readReg(5'h00, 0, 32'd1, 2'b00);
    readReg(5'h04, 0, 32'd2, 2'b00);
    readReg(5'h08, 0, 32'd3, 2'b00);
    readReg(5'h0C, 0, 32'd4, 2'b00);
    checkOutput("regout_seq", reg_out, 128'h00000004_00000003_00000002_00000001);

    writeReg(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 2'b00, pulse);
    checkOutput("strobe_pulse", pulse, 4'b0010);
    checkOutput("strobe_pulse_gone", reg_wr_pulse, 4'b0000);
    checkOutput("strobe_reg1", reg_out[63:32], 32'h00BB00DD);

    writeReg(5'h08, 32'h55, 4'hF, 3, 0, 2'b00, pulse);
    checkOutput("skew_reg2", reg_out[95:64], 32'h55);

    writeReg(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, OOR, pulse);
    checkOutput("oor_pulse", pulse, 4'b0000);
    readReg(5'h10, 0, 32'h0, OOR);
    checkOutput("oor_regout", reg_out, 128'h00000004_00000055_00BB00DD_00000001);

    writeReg(5'h0C, 32'h1234, 4'h0, 0, 0, 2'b00, pulse);
    checkOutput("nostrb_pulse", pulse, 4'b0000);
    writeReg(5'h0C, 32'h1234, 4'hF, 0, 5, 2'b00, pulse);
    readReg(5'h00, 5, 32'd1, 2'b00);
    checkOutput("bp_reg3", reg_out[127:96], 32'h1234);

    // Abort an open write response and an open read data phase with reset.
    @(negedge ACLK);
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    checkOutput("pre_reset_bvalid", S_AXI_BVALID, 1'b1);
    checkOutput("pre_reset_rvalid", S_AXI_RVALID, 1'b1);
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    checkOutput("abort_bvalid", S_AXI_BVALID, 1'b0);
    checkOutput("abort_rvalid", S_AXI_RVALID, 1'b0);
    checkOutput("abort_regout", reg_out, 128'h0);
    checkOutput("abort_awready", S_AXI_AWREADY, 1'b1);
    checkOutput("abort_wready", S_AXI_WREADY, 1'b1);
    checkOutput("abort_arready", S_AXI_ARREADY, 1'b1);
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    repeat (2) @(negedge ACLK);

    applyStimulus(4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
